boot_image_copier: RTL and testbench

- Sequences the boot-time copy of an OS image, word by word, from the SD image memory into a tightly-coupled instruction memory (ITCM).
- Holds the RISC-V core in reset until the copy finishes, then releases it.
- Sits between the SD image memory read port, the ITCM write port and the core's reset input.
- Start is automatic after reset, or on request by the boot ROM through `start`.

---
 rtl/boot_image_copier.sv | 203 ++++++++++++++++++++
 tb/tb_boot_image_copier.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_image_copier.sv
// boot_image_copier
//   Copies a boot image word by word from the SD image memory into the ITCM
//   and holds the RISC-V core in reset until the copy has completed.
//   A copy starts automatically on the first cycle after reset (AUTO_START=1)
//   or on a start pulse from the boot ROM while idle, done or in error.
//
//   Optional feature macro: BOOT_IMAGE_COPIER_CHECKSUM_EN
//     defined   : checksum is the 32-bit modulo sum of every accepted word
//     undefined : checksum is tied to zero, no adder is built
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   start               single-cycle copy request (ignored while busy)
//   cfg_len             number of words to copy, sampled at start
//   src_rd_en/src_addr  one-cycle read request to the image memory
//   src_rd_valid/_data  read response, latency >= 1 cycle
//   dst_we/_addr/_wdata ITCM write, held until dst_ready
//   dst_ready           ITCM accepts the write this cycle
//   cpu_rst_hold        1 keeps the core in reset (released only in DONE)
//   busy, done, error   status; done/error are sticky until the next start
//   checksum            running word sum (see macro above)
//
// State   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for auto-start or start
// S_READ  | issuing the single read request for word idx
// S_WAIT  | waiting for read data, timeout timer running
// S_WRITE | presenting word idx to the ITCM until accepted
// S_DONE  | copy complete, core released
// S_ERROR | read timeout, core held in reset
module boot_image_copier #(
  parameter int AW         = 14,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 0,
  parameter int TIMEOUT    = 255,
  parameter int AUTO_START = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   cfg_len,
  output logic          src_rd_en,
  output logic [AW-1:0] src_addr,
  input  logic          src_rd_valid,
  input  logic [31:0]   src_rd_data,
  output logic          dst_we,
  output logic [AW-1:0] dst_addr,
  output logic [31:0]   dst_wdata,
  input  logic          dst_ready,
  output logic          cpu_rst_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [31:0]   checksum
);

  // Timer only has to count up to TIMEOUT-1: the TIMEOUT-th WAIT cycle
  // is the one that leaves for S_ERROR.
  localparam int            TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] SRC_B  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_B  = AW'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_auto;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_idx;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_wdata;
  logic          w_launch;
  logic          w_capture;
  logic          w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    src_rd_en    = 1'b0;
    dst_we       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    cpu_rst_hold = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto) begin
          w_launch    = 1'b1;
          w_state_nxt = (cfg_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        src_rd_en   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // valid is tested first so a response on the timeout cycle wins
        if (src_rd_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (r_timer == T_LAST) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_WRITE: begin
        busy   = 1'b1;
        dst_we = 1'b1;
        if (dst_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = (r_cnt == (AW+1)'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        cpu_rst_hold = 1'b0;
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = (cfg_len == '0) ? S_DONE : S_READ;
        end
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = (cfg_len == '0) ? S_DONE : S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto  <= (AUTO_START != 0);
      r_cnt   <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_wdata <= '0;
    end else begin
      r_auto <= 1'b0;
      if (w_launch) begin
        r_cnt <= cfg_len;
        r_idx <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt - (AW+1)'(1);
        r_idx <= r_idx + AW'(1);
      end
      if (r_state == S_READ) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_capture) begin
        r_wdata <= src_rd_data;
      end
    end
  end

  // Addresses read as zero outside the states that use them, so the
  // buses sit at zero in reset/idle regardless of the base parameters.
  assign src_addr  = (r_state == S_READ || r_state == S_WAIT) ? SRC_B + r_idx : '0;
  assign dst_addr  = (r_state == S_WRITE) ? DST_B + r_idx : '0;
  assign dst_wdata = r_wdata;

`ifdef BOOT_IMAGE_COPIER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_launch) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + r_wdata;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_boot_image_copier.sv
module tb_boot_image_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b0;

  // main instance, AW=14
  logic        start0 = 1'b0;
  logic [14:0] len0 = '0;
  logic        rd_en0, we0, ready0, valid0;
  logic [13:0] src_addr0, dst_addr0;
  logic [31:0] rdata0, wdata0, cks0;
  logic        hold0, busy0, done0, err0;

  // wrap instance, AW=4
  logic        start1 = 1'b0;
  logic [4:0]  len1 = 5'd4;
  logic        rd_en1, we1, valid1;
  logic        ready1 = 1'b1;
  logic [3:0]  src_addr1, dst_addr1;
  logic [31:0] rdata1, wdata1, cks1;
  logic        hold1, busy1, done1, err1;

  boot_image_copier #(.AW(14), .SRC_BASE(0), .DST_BASE(0), .TIMEOUT(255), .AUTO_START(1)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .cfg_len(len0),
    .src_rd_en(rd_en0), .src_addr(src_addr0), .src_rd_valid(valid0), .src_rd_data(rdata0),
    .dst_we(we0), .dst_addr(dst_addr0), .dst_wdata(wdata0), .dst_ready(ready0),
    .cpu_rst_hold(hold0), .busy(busy0), .done(done0), .error(err0), .checksum(cks0));

  boot_image_copier #(.AW(4), .SRC_BASE(14), .DST_BASE(14), .TIMEOUT(15), .AUTO_START(0)) u1 (
    .clk(clk), .rst(rst0), .start(start1), .cfg_len(len1),
    .src_rd_en(rd_en1), .src_addr(src_addr1), .src_rd_valid(valid1), .src_rd_data(rdata1),
    .dst_we(we1), .dst_addr(dst_addr1), .dst_wdata(wdata1), .dst_ready(ready1),
    .cpu_rst_hold(hold1), .busy(busy1), .done(done1), .error(err1), .checksum(cks1));

  int n_checks = 0;
  int n_fail   = 0;

  // environment model for u0
  logic [31:0] src_mem [0:16383];
  logic [13:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          rd_lat = 1;      // 0 = source never answers
  int          rand_ready = 0;
  int          spur_en = 0;
  int          bp_left = 0;
  int          rd_cnt = 0;
  int          pend0 = 0;
  int          pcnt0 = 0;
  logic [13:0] paddr0 = '0;

  initial begin
    valid0 = 1'b0;
    ready0 = 1'b1;
    rdata0 = '0;
  end

  always @(negedge clk) begin
    if (rst0) begin
      pend0  = 0;
      valid0 = 1'b0;
      ready0 = 1'b1;
    end else begin
      if (we0 && bp_left > 0) begin
        ready0 = 1'b0;
        bp_left--;
      end else if (rand_ready != 0) begin
        ready0 = ($urandom_range(0, 2) != 0);
      end else begin
        ready0 = 1'b1;
      end
      if (we0 && ready0) begin
        wq_addr.push_back(dst_addr0);
        wq_data.push_back(wdata0);
      end
      valid0 = 1'b0;
      rdata0 = $urandom;
      if (pend0 != 0 && rd_lat > 0) begin
        pcnt0--;
        if (pcnt0 == 0) begin
          valid0 = 1'b1;
          rdata0 = src_mem[paddr0];
          pend0  = 0;
        end
      end
      if (rd_en0) begin
        rd_cnt++;
        pend0  = 1;
        pcnt0  = rd_lat;
        paddr0 = src_addr0;
        if (spur_en != 0) valid0 = 1'b1;  // garbage in READ, must be ignored
      end
    end
  end

  // environment model for u1: 1-cycle latency, always ready
  logic [3:0] q_src1 [$];
  logic [3:0] q_dst1 [$];
  logic [31:0] q_dat1 [$];
  int          pend1 = 0;
  logic [3:0]  paddr1 = '0;

  initial begin
    valid1 = 1'b0;
    rdata1 = '0;
  end

  always @(negedge clk) begin
    if (rst0) begin
      pend1  = 0;
      valid1 = 1'b0;
    end else begin
      valid1 = 1'b0;
      if (pend1 != 0) begin
        valid1 = 1'b1;
        rdata1 = 32'hC0DE0000 | {28'h0, paddr1};
        pend1  = 0;
      end
      if (rd_en1) begin
        pend1  = 1;
        paddr1 = src_addr1;
        q_src1.push_back(src_addr1);
      end
      if (we1) begin
        q_dst1.push_back(dst_addr1);
        q_dat1.push_back(wdata1);
      end
    end
  end

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst0 = 1'b1;
    #2;
    n_checks++;
    if ({rd_en0, we0, busy0, done0, err0, hold0} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000001", {rd_en0, we0, busy0, done0, err0, hold0});
    end
    n_checks++;
    if ({src_addr0, dst_addr0, wdata0, cks0} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: src %h dst %h wdata %h cks %h want all 0", src_addr0, dst_addr0, wdata0, cks0);
    end
    n_checks++;
    if ({hold1, busy1, done1, err1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_u1: got %b want 1000", {hold1, busy1, done1, err1});
    end
  endtask

  task automatic test_auto_start();
    int cyc;
    int hold_bad;
    logic [31:0] sum;
    logic [31:0] exp_cks;
    for (int i = 0; i < 4; i++) src_mem[i] = 32'h11111111 * (i + 1);
    len0 = 15'd4;
    rd_lat = 1;
    rand_ready = 0;
    spur_en = 0;
    @(negedge clk);
    rst0 = 1'b0;
    cyc = 0;
    hold_bad = 0;
    while (!done0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!done0 && hold0 !== 1'b1) hold_bad = 1;
    end
    n_checks++;
    if (cyc != 13) begin
      n_fail++;
      $display("FAIL auto_done_cycle: done after %0d cycles want 13", cyc);
    end
    n_checks++;
    if (hold0 !== 1'b0 || hold_bad != 0) begin
      n_fail++;
      $display("FAIL auto_hold: hold %b early_drop %0d want 0/0", hold0, hold_bad);
    end
    n_checks++;
    if (wq_addr.size() != 4) begin
      n_fail++;
      $display("FAIL auto_nwrites: %0d want 4", wq_addr.size());
    end else begin
      sum = '0;
      for (int i = 0; i < 4; i++) begin
        sum += 32'h11111111 * (i + 1);
        n_checks++;
        if (wq_addr[i] !== 14'(i) || wq_data[i] !== 32'h11111111 * (i + 1)) begin
          n_fail++;
          $display("FAIL auto_write%0d: addr %h data %h want %h %h", i, wq_addr[i], wq_data[i], i, 32'h11111111 * (i + 1));
        end
      end
`ifdef BOOT_IMAGE_COPIER_CHECKSUM_EN
      exp_cks = sum;
`else
      exp_cks = 32'h0;
`endif
      n_checks++;
      if (cks0 !== exp_cks) begin
        n_fail++;
        $display("FAIL auto_checksum: %h want %h", cks0, exp_cks);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int cyc;
    wq_addr.delete();
    wq_data.delete();
    len0 = 15'd2;
    rd_lat = 1;
    rand_ready = 0;
    bp_left = 5;
    pulse_start0();
    n = 0;
    while (!we0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (we0 !== 1'b1 || dst_addr0 !== 14'd0 || wdata0 !== src_mem[0]) begin
        n_fail++;
        $display("FAIL bp_hold%0d: we %b addr %h data %h want 1 0000 %h", k, we0, dst_addr0, wdata0, src_mem[0]);
      end
      @(negedge clk);
    end
    cyc = 0;
    while (!done0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!done0 || wq_addr.size() != 2) begin
      n_fail++;
      $display("FAIL bp_writes: done %b writes %0d want 1 2", done0, wq_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (wq_addr[i] !== 14'(i) || wq_data[i] !== src_mem[i]) begin
          n_fail++;
          $display("FAIL bp_write%0d: addr %h data %h want %h %h", i, wq_addr[i], wq_data[i], i, src_mem[i]);
        end
      end
    end
  endtask

  task automatic test_random_copies();
    int len;
    int cyc;
    logic [31:0] sum;
    logic [31:0] exp_cks;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        len = 6; rd_lat = 1; rand_ready = 0; spur_en = 0;
      end else begin
        len = $urandom_range(3, 24);
        rd_lat = $urandom_range(1, 4);
        rand_ready = 1;
        spur_en = 1;
      end
      for (int i = 0; i < len; i++) src_mem[i] = $urandom;
      wq_addr.delete();
      wq_data.delete();
      len0 = 15'(len);
      pulse_start0();
      cyc = 1;
      while (!(done0 || err0) && cyc < 400) begin
        if (cyc == 5) start0 = 1'b1;   // must be ignored while busy
        @(negedge clk);
        start0 = 1'b0;
        cyc++;
      end
      start0 = 1'b0;
      if (it == 0) begin
        n_checks++;
        if (cyc != 19) begin
          n_fail++;
          $display("FAIL latency6: done at cycle %0d want 19", cyc);
        end
      end
      n_checks++;
      if (done0 !== 1'b1 || err0 !== 1'b0 || wq_addr.size() != len) begin
        n_fail++;
        $display("FAIL rand%0d_status: done %b err %b writes %0d want 1 0 %0d", it, done0, err0, wq_addr.size(), len);
      end else begin
        sum = '0;
        for (int i = 0; i < len; i++) begin
          sum += src_mem[i];
          n_checks++;
          if (wq_addr[i] !== 14'(i) || wq_data[i] !== src_mem[i]) begin
            n_fail++;
            $display("FAIL rand%0d_write%0d: addr %h data %h want %h %h", it, i, wq_addr[i], wq_data[i], i, src_mem[i]);
          end
        end
`ifdef BOOT_IMAGE_COPIER_CHECKSUM_EN
        exp_cks = sum;
`else
        exp_cks = 32'h0;
`endif
        n_checks++;
        if (cks0 !== exp_cks) begin
          n_fail++;
          $display("FAIL rand%0d_checksum: %h want %h", it, cks0, exp_cks);
        end
      end
    end
    rand_ready = 0;
    spur_en = 0;
  endtask

  task automatic test_timeout();
    int cyc;
    wq_addr.delete();
    wq_data.delete();
    rd_lat = 0;
    len0 = 15'd3;
    pulse_start0();
    cyc = 1;
    while (!(done0 || err0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (err0 !== 1'b1 || cyc != 257) begin
      n_fail++;
      $display("FAIL timeout_cycle: err %b at cycle %0d want 1 at 257", err0, cyc);
    end
    n_checks++;
    if ({hold0, busy0, done0} !== 3'b100 || wq_addr.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_state: hold/busy/done %b writes %0d want 100 0", {hold0, busy0, done0}, wq_addr.size());
    end
  endtask

  task automatic test_recovery();
    int cyc;
    rd_lat = 1;
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < 5; i++) src_mem[i] = $urandom;
    len0 = 15'd5;
    pulse_start0();
    cyc = 1;
    n_checks++;
    if (err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_err_clear: err %b want 0", err0);
    end
    while (!(done0 || err0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || wq_addr.size() != 5) begin
      n_fail++;
      $display("FAIL recover_status: done %b err %b writes %0d want 1 0 5", done0, err0, wq_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (wq_data[i] !== src_mem[i] || wq_addr[i] !== 14'(i)) begin
          n_fail++;
          $display("FAIL recover_write%0d: addr %h data %h want %h %h", i, wq_addr[i], wq_data[i], i, src_mem[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int rd_before;
    wq_addr.delete();
    wq_data.delete();
    rd_before = rd_cnt;
    len0 = 15'd0;
    pulse_start0();
    n_checks++;
    if ({done0, err0, busy0, hold0} !== 4'b1000) begin
      n_fail++;
      $display("FAIL zero_state: done/err/busy/hold %b want 1000", {done0, err0, busy0, hold0});
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (rd_cnt != rd_before || wq_addr.size() != 0 || cks0 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_activity: reads %0d writes %0d cks %h want 0 0 0", rd_cnt - rd_before, wq_addr.size(), cks0);
    end
  endtask

  task automatic test_reset_midcopy();
    int base;
    int n;
    for (int i = 0; i < 8; i++) src_mem[i] = $urandom;
    len0 = 15'd8;
    rd_lat = 4;
    base = rd_cnt;
    pulse_start0();
    #1;
    n = 0;
    while (rd_cnt < base + 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy0, rd_en0, we0} !== 3'b100 || src_addr0 !== 14'd2) begin
      n_fail++;
      $display("FAIL mid_in_wait: busy/rd/we %b src %h want 100 0002", {busy0, rd_en0, we0}, src_addr0);
    end
    rst0 = 1'b1;
    #1;
    n_checks++;
    if ({rd_en0, we0, busy0, done0, err0, hold0} !== 6'b000001 ||
        {src_addr0, dst_addr0, wdata0, cks0} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset: ctrl %b src %h dst %h wdata %h cks %h want 000001 and zeros",
               {rd_en0, we0, busy0, done0, err0, hold0}, src_addr0, dst_addr0, wdata0, cks0);
    end
    @(negedge clk);
    wq_addr.delete();
    wq_data.delete();
    rd_lat = 1;
    @(negedge clk);
    rst0 = 1'b0;
    n = 0;
    while (!rd_en0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rd_en0 !== 1'b1 || src_addr0 !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_restart_addr: rd %b src %h want 1 0000", rd_en0, src_addr0);
    end
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done0 !== 1'b1 || wq_addr.size() != 8) begin
      n_fail++;
      $display("FAIL mid_restart_done: done %b writes %0d want 1 8", done0, wq_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (wq_addr[i] !== 14'(i) || wq_data[i] !== src_mem[i]) begin
          n_fail++;
          $display("FAIL mid_write%0d: addr %h data %h want %h %h", i, wq_addr[i], wq_data[i], i, src_mem[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [3:0]  a;
    logic [31:0] sum;
    logic [31:0] exp_cks;
    q_src1.delete();
    q_dst1.delete();
    q_dat1.delete();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done1 !== 1'b1 || err1 !== 1'b0 || busy1 !== 1'b0 || q_src1.size() != 4 || q_dst1.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_status: done %b err %b busy %b reads %0d writes %0d want 1 0 0 4 4",
               done1, err1, busy1, q_src1.size(), q_dst1.size());
    end else begin
      sum = '0;
      for (int i = 0; i < 4; i++) begin
        a = 4'((14 + i) % 16);
        sum += 32'hC0DE0000 | {28'h0, a};
        n_checks++;
        if (q_src1[i] !== a || q_dst1[i] !== a || q_dat1[i] !== (32'hC0DE0000 | {28'h0, a})) begin
          n_fail++;
          $display("FAIL wrap_word%0d: src %0d dst %0d data %h want %0d %0d %h",
                   i, q_src1[i], q_dst1[i], q_dat1[i], a, a, 32'hC0DE0000 | {28'h0, a});
        end
      end
`ifdef BOOT_IMAGE_COPIER_CHECKSUM_EN
      exp_cks = sum;
`else
      exp_cks = 32'h0;
`endif
      n_checks++;
      if (cks1 !== exp_cks || hold1 !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_cks_hold: cks %h hold %b want %h 0", cks1, hold1, exp_cks);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) src_mem[i] = $urandom;
    test_reset();
    test_auto_start();
    test_backpressure();
    test_random_copies();
    test_timeout();
    test_recovery();
    test_zero_len();
    test_reset_midcopy();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
